ps2_xt_keyconv: RTL and testbench

- Converts `hps_io` `ps2_key` events (PS/2 set 2) into IBM XT set 1 scancode bytes.
- Buffers the bytes in a small FIFO and presents them to the XT keyboard interface inside `system` (port 60h / IRQ1 path) through a valid/ack handshake.
- Sits between `hps_io` and `system`, in the `clk_sys` (14.318 MHz) domain.
- A CDC stage upstream is owned by the top level.

---
 rtl/ps2xt_pkg.sv | 21 ++
 rtl/ps2xt_rom.sv | 49 ++++
 rtl/ps2_xt_keyconv.sv | 140 ++++++++++++++
 tb/tb_ps2_xt_keyconv.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2xt_pkg.sv
// Shared types and constants for the PS/2 set 2 to XT set 1 key converter.
package ps2xt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        PUSH_PFX,
        PUSH_CODE
    } state_t;

    localparam logic [7:0] XT_EXT_PREFIX = 8'hE0;
    localparam int         XT_BREAK_BIT  = 7;
    localparam logic [7:0] XT_NONE       = 8'h00;

    typedef struct packed {
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } key_evt_t;

endpackage

// File: rtl/ps2xt_rom.sv
// Set 2 to set 1 make-code table with one cycle of read latency.
// Codes with no XT equivalent read back as XT_NONE.
module ps2xt_rom
    import ps2xt_pkg::*;
(
    input  logic       clk_sys,
    input  logic [7:0] addr_i,
    output logic [7:0] data_o
);

    logic [7:0] data_d;
    logic [7:0] data_q;

    always_comb begin
        data_d = XT_NONE;
        case (addr_i)
            8'h01: data_d = 8'h43;  8'h03: data_d = 8'h3F;  8'h04: data_d = 8'h3D;  8'h05: data_d = 8'h3B;
            8'h06: data_d = 8'h3C;  8'h07: data_d = 8'h58;  8'h09: data_d = 8'h44;  8'h0A: data_d = 8'h42;
            8'h0B: data_d = 8'h40;  8'h0C: data_d = 8'h3E;  8'h0D: data_d = 8'h0F;  8'h0E: data_d = 8'h29;
            8'h11: data_d = 8'h38;  8'h12: data_d = 8'h2A;  8'h14: data_d = 8'h1D;  8'h15: data_d = 8'h10;
            8'h16: data_d = 8'h02;  8'h1A: data_d = 8'h2C;  8'h1B: data_d = 8'h1F;  8'h1C: data_d = 8'h1E;
            8'h1D: data_d = 8'h11;  8'h1E: data_d = 8'h03;  8'h21: data_d = 8'h2E;  8'h22: data_d = 8'h2D;
            8'h23: data_d = 8'h20;  8'h24: data_d = 8'h12;  8'h25: data_d = 8'h05;  8'h26: data_d = 8'h04;
            8'h29: data_d = 8'h39;  8'h2A: data_d = 8'h2F;  8'h2B: data_d = 8'h21;  8'h2C: data_d = 8'h14;
            8'h2D: data_d = 8'h13;  8'h2E: data_d = 8'h06;  8'h31: data_d = 8'h31;  8'h32: data_d = 8'h30;
            8'h33: data_d = 8'h23;  8'h34: data_d = 8'h22;  8'h35: data_d = 8'h15;  8'h36: data_d = 8'h07;
            8'h3A: data_d = 8'h32;  8'h3B: data_d = 8'h24;  8'h3C: data_d = 8'h16;  8'h3D: data_d = 8'h08;
            8'h3E: data_d = 8'h09;  8'h41: data_d = 8'h33;  8'h42: data_d = 8'h25;  8'h43: data_d = 8'h17;
            8'h44: data_d = 8'h18;  8'h45: data_d = 8'h0B;  8'h46: data_d = 8'h0A;  8'h49: data_d = 8'h34;
            8'h4A: data_d = 8'h35;  8'h4B: data_d = 8'h26;  8'h4C: data_d = 8'h27;  8'h4D: data_d = 8'h19;
            8'h4E: data_d = 8'h0C;  8'h52: data_d = 8'h28;  8'h54: data_d = 8'h1A;  8'h55: data_d = 8'h0D;
            8'h58: data_d = 8'h3A;  8'h59: data_d = 8'h36;  8'h5A: data_d = 8'h1C;  8'h5B: data_d = 8'h1B;
            8'h5D: data_d = 8'h2B;  8'h66: data_d = 8'h0E;  8'h69: data_d = 8'h4F;  8'h6B: data_d = 8'h4B;
            8'h6C: data_d = 8'h47;  8'h70: data_d = 8'h52;  8'h71: data_d = 8'h53;  8'h72: data_d = 8'h50;
            8'h73: data_d = 8'h4C;  8'h74: data_d = 8'h4D;  8'h75: data_d = 8'h48;  8'h76: data_d = 8'h01;
            8'h77: data_d = 8'h45;  8'h78: data_d = 8'h57;  8'h79: data_d = 8'h4E;  8'h7A: data_d = 8'h51;
            8'h7B: data_d = 8'h4A;  8'h7C: data_d = 8'h37;  8'h7D: data_d = 8'h49;  8'h7E: data_d = 8'h46;
            8'h83: data_d = 8'h41;
            default: data_d = XT_NONE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/ps2_xt_keyconv.sv
// Turns hps_io ps2_key toggle events into XT set 1 bytes, queued in a FIFO
// and handed to the XT keyboard port through a valid/ack handshake.
module ps2_xt_keyconv
    import ps2xt_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        kbd_clear,
    output logic [7:0]  xt_data,
    output logic        xt_valid,
    input  logic        xt_ack,
    output logic        overflow
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);

    state_t         state_q;
    logic           armed_q, prev_tog_q, pend_v_q, overflow_q;
    key_evt_t       cur_q, pend_q, new_evt;
    logic [7:0]     m_q, rom_addr, rom_data, push_data, xt_data_q, xt_data_d;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt, count, free_slots, need;
    logic           evt_hit, push, pop;

    assign new_evt  = key_evt_t'(ps2_key[9:0]);
    assign evt_hit  = armed_q && (ps2_key[10] != prev_tog_q);
    // Only meaningful in IDLE, where a queued event takes priority.
    assign rom_addr = pend_v_q ? pend_q.code : new_evt.code;

    ps2xt_rom u_rom (
        .clk_sys (clk_sys),
        .addr_i  (rom_addr),
        .data_o  (rom_data)
    );

    assign count      = wr_ptr_q - rd_ptr_q;
    assign free_slots = DEPTH_C - count;
    assign need       = cur_q.ext ? TWO_C : ONE_C;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            prev_tog_q <= 1'b0;
            cur_q      <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            m_q        <= XT_NONE;
            overflow_q <= 1'b0;
        end else begin
            prev_tog_q <= ps2_key[10];
            armed_q    <= 1'b1;
            overflow_q <= 1'b0;
            if (kbd_clear) begin
                state_q  <= IDLE;
                pend_v_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pend_v_q) begin
                            cur_q    <= pend_q;
                            state_q  <= LOOKUP;
                            pend_v_q <= evt_hit;
                            if (evt_hit) pend_q <= new_evt;
                        end else if (evt_hit) begin
                            cur_q   <= new_evt;
                            state_q <= LOOKUP;
                        end
                    end
                    LOOKUP: begin
                        m_q <= rom_data;
                        // Room for the whole sequence is reserved here so a prefix never goes out alone.
                        if (rom_data == XT_NONE) begin
                            state_q <= IDLE;
                        end else if (free_slots < need) begin
                            overflow_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            state_q <= cur_q.ext ? PUSH_PFX : PUSH_CODE;
                        end
                    end
                    PUSH_PFX:  state_q <= PUSH_CODE;
                    PUSH_CODE: state_q <= IDLE;
                    default:   state_q <= IDLE;
                endcase
                if (evt_hit && state_q != IDLE) begin
                    if (pend_v_q) begin
                        overflow_q <= 1'b1;
                    end else begin
                        pend_q   <= new_evt;
                        pend_v_q <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        push_data = m_q;
        push_data[XT_BREAK_BIT] = m_q[XT_BREAK_BIT] | ~cur_q.pressed;
        if (state_q == PUSH_PFX) push_data = XT_EXT_PREFIX;
    end

    assign push = !kbd_clear && (state_q == PUSH_PFX || state_q == PUSH_CODE);
    assign pop  = !kbd_clear && xt_ack && (wr_ptr_q != rd_ptr_q);

    assign rd_ptr_nxt = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    // Bypass the array when the new head is the byte being written this cycle.
    assign xt_data_d  = (push && rd_ptr_nxt == wr_ptr_q) ? push_data : mem[rd_ptr_nxt[PTR_W-1:0]];

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            xt_data_q <= 8'h00;
        end else if (kbd_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ONE_C;
            rd_ptr_q  <= rd_ptr_nxt;
            xt_data_q <= xt_data_d;
        end
    end

    assign xt_data  = xt_data_q;
    assign xt_valid = (wr_ptr_q != rd_ptr_q);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_xt_keyconv.sv
// Randomised scoreboard bench for ps2_xt_keyconv against a queue-level key model.
module tb_ps2_xt_keyconv;

    localparam int DEPTH = 8;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = '0;
    logic        kbd_clear = 1'b0;
    logic [7:0]  xt_data;
    logic        xt_valid;
    logic        xt_ack = 1'b0;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;
    int ovf_seen = 0;
    int ovf_exp = 0;
    bit ack_en = 1'b0;
    bit ack_one = 1'b0;
    int ack_pct = 100;
    logic [7:0] exp_q [$];

    logic [7:0] key_s2 [16] = '{8'h1C, 8'h83, 8'h75, 8'h76, 8'h5A, 8'h29, 8'h66, 8'h16,
                                8'h45, 8'h05, 8'h0D, 8'h12, 8'h14, 8'h11, 8'h7C, 8'h4A};
    logic [7:0] key_s1 [16] = '{8'h1E, 8'h41, 8'h48, 8'h01, 8'h1C, 8'h39, 8'h0E, 8'h02,
                                8'h0B, 8'h3B, 8'h0F, 8'h2A, 8'h1D, 8'h38, 8'h37, 8'h35};
    logic [7:0] bad_s2 [6]  = '{8'h00, 8'h02, 8'h08, 8'h10, 8'h60, 8'hFF};

    ps2_xt_keyconv #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_key   (ps2_key),
        .kbd_clear (kbd_clear),
        .xt_data   (xt_data),
        .xt_valid  (xt_valid),
        .xt_ack    (xt_ack),
        .overflow  (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [31:0] act);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    function automatic logic [7:0] s1_of(input logic [7:0] c);
        for (int i = 0; i < 16; i++)
            if (key_s2[i] == c) return key_s1[i];
        return 8'h00;
    endfunction

    // Scoreboard consumer: pops and compares whenever it acks a presented byte.
    always @(negedge clk_sys) begin
        xt_ack = 1'b0;
        if (!reset) begin
            if (overflow) ovf_seen++;
            if (xt_valid && (ack_one || (ack_en && $urandom_range(99) < ack_pct))) begin
                if (exp_q.size() == 0) note_fail("unexpected_byte", 32'(xt_data));
                else check("byte_order", 32'(xt_data), 32'(exp_q.pop_front()));
                xt_ack = 1'b1;
            end
            ack_one = 1'b0;
        end
    end

    task automatic toggle(input logic p, input logic e, input logic [7:0] c);
        @(negedge clk_sys);
        ps2_key = {~ps2_key[10], p, e, c};
    endtask

    // Issue one event and record what the XT side must eventually see.
    task automatic send_evt(input logic p, input logic e, input logic [7:0] c, input int gap);
        logic [7:0] m;
        int n;
        toggle(p, e, c);
        m = s1_of(c);
        n = e ? 2 : 1;
        if (m != 8'h00) begin
            if (DEPTH - exp_q.size() < n) begin
                ovf_exp++;
            end else begin
                if (e) exp_q.push_back(8'hE0);
                exp_q.push_back(p ? m : (m | 8'h80));
            end
        end
        repeat (gap) @(negedge clk_sys);
    endtask

    task automatic drain(input string name);
        int k;
        ack_pct = 100;
        ack_en = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk_sys);
            k++;
        end
        if (exp_q.size() != 0) note_fail({name, "_drain_timeout"}, 32'(exp_q.size()));
        repeat (3) @(negedge clk_sys);
        check({name, "_empty_after"}, 32'(xt_valid), 32'd0);
        ack_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        repeat (3) @(negedge clk_sys);
        check("rst_valid", 32'(xt_valid), 32'd0);
        check("rst_data", 32'(xt_data), 32'h00);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("arm_no_event", 32'(xt_valid), 32'd0);

        // Single key, latency of three edges, then ack empties the FIFO.
        send_evt(1'b1, 1'b0, 8'h1C, 0);
        @(negedge clk_sys); check("lat1_n1", 32'(xt_valid), 32'd0);
        @(negedge clk_sys); check("lat1_n2", 32'(xt_valid), 32'd0);
        @(negedge clk_sys); check("lat1_n3_valid", 32'(xt_valid), 32'd1);
        check("lat1_n3_data", 32'(xt_data), 32'h1E);
        drain("t1");

        send_evt(1'b0, 1'b0, 8'h1C, 5);
        send_evt(1'b1, 1'b0, 8'h83, 5);
        drain("t2");

        // Extended key: prefix appears at the head with the same latency.
        send_evt(1'b1, 1'b1, 8'h75, 0);
        repeat (2) @(negedge clk_sys);
        @(negedge clk_sys); check("lat_ext_valid", 32'(xt_valid), 32'd1);
        check("lat_ext_head", 32'(xt_data), 32'hE0);
        repeat (3) @(negedge clk_sys);
        send_evt(1'b0, 1'b1, 8'h75, 6);
        drain("t3");

        // Untranslatable codes vanish silently.
        send_evt(1'b1, 1'b0, 8'h02, 5);
        send_evt(1'b1, 1'b1, 8'h60, 5);
        check("unmapped_valid", 32'(xt_valid), 32'd0);
        check("unmapped_ovf", 32'(ovf_seen), 32'(ovf_exp));

        // Fill to 7, extended event must be dropped whole, then one more fits.
        for (int i = 0; i < 7; i++) send_evt(1'b1, 1'b0, key_s2[i], 5);
        send_evt(1'b1, 1'b1, 8'h75, 6);
        check("t4_ext_drop_ovf", 32'(ovf_seen), 32'(ovf_exp));
        check("t4_head_kept", 32'(xt_data), 32'(exp_q[0]));
        send_evt(1'b1, 1'b0, 8'h76, 6);
        check("t4_ovf_after_fit", 32'(ovf_seen), 32'(ovf_exp));
        send_evt(1'b1, 1'b0, 8'h5A, 6);
        check("t4_full_drop_ovf", 32'(ovf_seen), 32'(ovf_exp));
        check("t4_ovf_total", 32'(ovf_exp), 32'(ovf_seen));
        drain("t4");

        // Pop in the same cycle as the push at high occupancy.
        for (int i = 0; i < 7; i++) send_evt(1'b0, 1'b0, key_s2[i+8], 5);
        send_evt(1'b1, 1'b0, 8'h29, 0);
        @(negedge clk_sys);
        #1 ack_one = 1'b1;
        repeat (5) @(negedge clk_sys);
        send_evt(1'b1, 1'b0, 8'h66, 6);
        send_evt(1'b1, 1'b0, 8'h16, 6);
        check("t5_count_ovf", 32'(ovf_seen), 32'(ovf_exp));
        drain("t5");

        // Back-to-back toggles: second waits in pending, third is lost.
        toggle(1'b1, 1'b0, 8'h45);
        toggle(1'b1, 1'b0, 8'h05);
        toggle(1'b1, 1'b0, 8'h0D);
        exp_q.push_back(8'h0B);
        exp_q.push_back(8'h3B);
        ovf_exp++;
        repeat (10) @(negedge clk_sys);
        check("t6_pending_ovf", 32'(ovf_seen), 32'(ovf_exp));
        drain("t6");

        // kbd_clear flushes immediately and swallows events without overflow.
        for (int i = 0; i < 3; i++) send_evt(1'b1, 1'b0, key_s2[i+3], 5);
        check("clr_before", 32'(xt_valid), 32'd1);
        @(negedge clk_sys); kbd_clear = 1'b1;
        @(negedge clk_sys); check("clr_valid", 32'(xt_valid), 32'd0);
        exp_q.delete();
        toggle(1'b1, 1'b0, 8'h1C);
        repeat (4) @(negedge clk_sys);
        kbd_clear = 1'b0;
        repeat (6) @(negedge clk_sys);
        check("clr_after_valid", 32'(xt_valid), 32'd0);
        check("clr_no_ovf", 32'(ovf_seen), 32'(ovf_exp));

        // Reset in the middle of an extended sequence.
        toggle(1'b1, 1'b1, 8'h75);
        repeat (3) @(negedge clk_sys);
        check("mid_pfx_pushed", 32'(xt_data), 32'hE0);
        reset = 1'b1;
        ps2_key[10] = ~ps2_key[10];
        @(negedge clk_sys);
        check("mid_rst_valid", 32'(xt_valid), 32'd0);
        check("mid_rst_data", 32'(xt_data), 32'h00);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk_sys);
        check("rearm_no_event", 32'(xt_valid), 32'd0);
        send_evt(1'b1, 1'b1, 8'h14, 6);
        drain("rearm");

        // Random traffic with a randomly stalling consumer.
        ack_pct = 60;
        ack_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int k;
            k = 0;
            while (exp_q.size() > 5 && k < 100) begin
                @(negedge clk_sys);
                k++;
            end
            if (exp_q.size() > 5) note_fail("rand_backlog", 32'(exp_q.size()));
            if ($urandom_range(9) == 0) begin
                idx = $urandom_range(5);
                send_evt(1'($urandom_range(1)), 1'($urandom_range(1)), bad_s2[idx], $urandom_range(8, 4));
            end else begin
                idx = $urandom_range(15);
                send_evt(1'($urandom_range(1)), 1'($urandom_range(1)), key_s2[idx], $urandom_range(8, 4));
            end
        end
        drain("rand");
        check("final_ovf", 32'(ovf_seen), 32'(ovf_exp));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
